p_s: RTL and testbench

Parallel-to-serial converter on the output side of the 16-point FFT datapath. It accepts a frame as four 4-lane beats of complex samples from the butterfly pipeline and reorders them through a ping-pong buffer. It then emits the frame one sample per cycle in natural index order, with valid and start-of-frame flags, to the serial FFT output port.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/p_s_bank.sv | 26 ++
 rtl/p_s.sv | 195 +++++++++++++++++++
 tb/tb_p_s.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath converters.
// Sample index mapping is shared by the serial/parallel input and output sides.
package fft_pkg;

  localparam int unsigned DATA_W  = 34;
  localparam int unsigned N_POINT = 16;
  localparam int unsigned LANES   = 4;
  localparam int unsigned BEATS   = N_POINT / LANES;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_READ
  } rd_state_t;

  // Beat k on lane L carries sample k + 4*L.
  function automatic logic [3:0] sample_idx(input logic [1:0] beat, input logic [1:0] lane);
    return {2'b00, beat} + {lane, 2'b00};
  endfunction

endpackage

// File: rtl/p_s_bank.sv
// One 16-sample frame buffer: 4-lane beat write port, asynchronous sample read port.
// Contents are intentionally not reset.
module p_s_bank
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    we,
  input  logic [1:0]              beat,
  input  logic [4*DATA_W-1:0]     wdata,
  input  logic [3:0]              raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [N_POINT];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned lane = 0; lane < LANES; lane++) begin
        mem[sample_idx(beat, lane[1:0])] <= wdata[lane*DATA_W +: DATA_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/p_s.sv
// Parallel-to-serial converter: reorders 4-lane beats through a ping-pong buffer
// and streams each frame one sample per cycle in natural index order.
module p_s
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*DATA_W-1:0]     data_in,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic [DATA_W-1:0]       data_out,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    ovf_err,
  output logic                    frame_err
);

  wr_state_t   wr_st, wr_nxt;
  logic [1:0]  wr_beat, wr_beat_nxt;
  logic        wr_bank, wr_bank_nxt;

  rd_state_t   rd_st, rd_nxt;
  logic [3:0]  rd_cnt, rd_cnt_nxt;
  logic        rd_bank, rd_bank_nxt;

  logic [1:0]  full_q, set_full, clr_full, bank_we;
  logic [1:0]  wr_beat_sel;
  logic        ovf_nxt, ferr_nxt;
  logic        out_valid_nxt, out_sof_nxt;
  logic [DATA_W-1:0] data_nxt, rd_data0, rd_data1;

  logic sof_beat, data_beat;
  assign sof_beat  = in_valid &  in_sof;
  assign data_beat = in_valid & ~in_sof;

  p_s_bank u_bank0 (
    .clk   (clk),
    .we    (bank_we[0]),
    .beat  (wr_beat_sel),
    .wdata (data_in),
    .raddr (rd_cnt),
    .rdata (rd_data0)
  );

  p_s_bank u_bank1 (
    .clk   (clk),
    .we    (bank_we[1]),
    .beat  (wr_beat_sel),
    .wdata (data_in),
    .raddr (rd_cnt),
    .rdata (rd_data1)
  );

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st   <= W_IDLE;
      wr_beat <= '0;
      wr_bank <= 1'b0;
      rd_st   <= R_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      full_q  <= '0;
    end else begin
      wr_st   <= wr_nxt;
      wr_beat <= wr_beat_nxt;
      wr_bank <= wr_bank_nxt;
      rd_st   <= rd_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
      // Set and clear never target the same bank: only non-full banks are written.
      full_q  <= (full_q | set_full) & ~clr_full;
    end
  end

  // ---------------- write next-state ----------------
  always_comb begin
    wr_nxt      = wr_st;
    wr_beat_nxt = wr_beat;
    wr_bank_nxt = wr_bank;
    unique case (wr_st)
      W_IDLE, W_DROP: begin
        if (sof_beat) begin
          if (!full_q[wr_bank]) begin
            wr_nxt      = W_FILL;
            wr_beat_nxt = 2'd1;
          end else begin
            wr_nxt      = W_DROP;
          end
        end
      end
      W_FILL: begin
        // A restart reuses the same, still non-full, bank.
        if (sof_beat) begin
          wr_beat_nxt = 2'd1;
        end else if (data_beat) begin
          if (wr_beat == 2'd3) begin
            wr_nxt      = W_IDLE;
            wr_beat_nxt = '0;
            wr_bank_nxt = ~wr_bank;
          end else begin
            wr_beat_nxt = wr_beat + 2'd1;
          end
        end
      end
      default: wr_nxt = W_IDLE;
    endcase
  end

  // ---------------- write outputs ----------------
  always_comb begin
    bank_we     = '0;
    set_full    = '0;
    wr_beat_sel = wr_beat;
    ovf_nxt     = 1'b0;
    ferr_nxt    = 1'b0;
    unique case (wr_st)
      W_IDLE, W_DROP: begin
        if (sof_beat) begin
          if (!full_q[wr_bank]) begin
            bank_we[wr_bank] = 1'b1;
            wr_beat_sel      = '0;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (sof_beat) begin
          ferr_nxt         = 1'b1;
          bank_we[wr_bank] = 1'b1;
          wr_beat_sel      = '0;
        end else if (data_beat) begin
          bank_we[wr_bank] = 1'b1;
          if (wr_beat == 2'd3) set_full[wr_bank] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- read next-state ----------------
  always_comb begin
    rd_nxt      = rd_st;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    unique case (rd_st)
      R_IDLE: begin
        if (full_q[rd_bank]) begin
          rd_nxt     = R_READ;
          rd_cnt_nxt = '0;
        end
      end
      R_READ: begin
        rd_cnt_nxt = rd_cnt + 4'd1;
        // Counter wraps to 0, so a ready second bank streams with no bubble.
        if (rd_cnt == 4'd15) begin
          rd_bank_nxt = ~rd_bank;
          if (!full_q[~rd_bank]) rd_nxt = R_IDLE;
        end
      end
      default: rd_nxt = R_IDLE;
    endcase
  end

  // ---------------- read outputs ----------------
  always_comb begin
    clr_full      = '0;
    out_valid_nxt = 1'b0;
    out_sof_nxt   = 1'b0;
    data_nxt      = rd_bank ? rd_data1 : rd_data0;
    if (rd_st == R_READ) begin
      out_valid_nxt = 1'b1;
      out_sof_nxt   = (rd_cnt == 4'd0);
      if (rd_cnt == 4'd15) clr_full[rd_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      ovf_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (out_valid_nxt) data_out <= data_nxt;
      out_valid <= out_valid_nxt;
      out_sof   <= out_sof_nxt;
      ovf_err   <= ovf_nxt;
      frame_err <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_p_s.sv
// Randomized self-checking bench for p_s against an edge-level frame model
// (bank occupancy and readout start computed from frame completion times).
module tb_p_s;

  localparam int W = 34;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*W-1:0]  data_in = '0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic [W-1:0]    data_out;
  logic            out_valid, out_sof, ovf_err, frame_err;

  p_s dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .ovf_err   (ovf_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  typedef struct {
    int         e;
    logic [W-1:0] d;
    bit         sof;
  } exp_t;

  exp_t    exp_q[$];
  int      last_q[$];      // edge at which each accepted frame's X[15] is registered
  bit      ovf_at[int];
  bit      ferr_at[int];
  bit      writing = 0;
  int      last_s = 0;
  logic [W-1:0] frame_x [16];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          exp_t ent;
          ent = exp_q.pop_front();
          check_eq("out_edge", 64'(edge_n), 64'(ent.e));
          check_eq("data_out", 64'(data_out), 64'(ent.d));
          check_eq("out_sof", 64'(out_sof), 64'(ent.sof));
        end
      end else if (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
        check_eq("missing_valid", 0, 1);
        void'(exp_q.pop_front());
      end
      check_eq("ovf_err", 64'(ovf_err), 64'(ovf_at.exists(edge_n)));
      check_eq("frame_err", 64'(frame_err), 64'(ferr_at.exists(edge_n)));
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one beat; t returns the edge that captures it.
  task automatic drive_beat(input logic [4*W-1:0] d, input bit sof, output int t);
    data_in  = d;
    in_valid = 1'b1;
    in_sof   = sof;
    @(posedge clk);
    #1;
    t = edge_n;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int nb, input int gap);
    bit accept = 0;
    int t;
    for (int b = 0; b < nb; b++) begin
      logic [4*W-1:0] d;
      for (int l = 0; l < 4; l++) d[l*W +: W] = frame_x[b + 4*l];
      drive_beat(d, b == 0, t);
      if (b == 0) begin
        if (writing) begin
          ferr_at[t] = 1;
          accept = 1;
        end else begin
          int nd = last_q.size();
          accept = (nd < 2) || (last_q[nd-2] < t);
        end
        if (!accept) ovf_at[t] = 1;
        writing = accept;
      end else if (b == 3 && accept) begin
        int s;
        int nd = last_q.size();
        s = (nd > 0 && t < last_q[nd-1]) ? last_q[nd-1] + 1 : t + 2;
        for (int i = 0; i < 16; i++) exp_q.push_back('{e: s + i, d: frame_x[i], sof: (i == 0)});
        last_q.push_back(s + 15);
        last_s = s;
        writing = 0;
      end
      if (b < nb - 1) idle(gap);
    end
  endtask

  task automatic set_frame(input logic [W-1:0] base);
    for (int i = 0; i < 16; i++) frame_x[i] = base + W'(i);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) frame_x[i] = W'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      check_eq("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    idle(3);
  endtask

  initial begin
    #12;
    check_eq("rst_data_out", 64'(data_out), 0);
    check_eq("rst_out_valid", 64'(out_valid), 0);
    check_eq("rst_out_sof", 64'(out_sof), 0);
    check_eq("rst_ovf_err", 64'(ovf_err), 0);
    check_eq("rst_frame_err", 64'(frame_err), 0);
    rst_n = 1'b1;
    idle(3);

    // Stray non-sof beat while idle is ignored.
    begin
      int t;
      drive_beat({4*W{1'b1}}, 1'b0, t);
    end
    idle(2);

    set_frame(34'h100);
    send_frame(4, 0);
    drain();

    set_frame(34'h100);
    send_frame(4, 0);
    idle(12);
    set_frame(34'h200);
    send_frame(4, 0);
    drain();

    set_frame(34'h100);
    send_frame(4, 3);
    drain();

    set_frame(34'h100);
    send_frame(4, 0);
    set_frame(34'h200);
    send_frame(4, 0);
    set_frame(34'h900);
    send_frame(4, 0);
    drain();

    set_frame(34'h3AA);
    send_frame(2, 0);
    set_frame(34'h300);
    send_frame(4, 0);
    drain();

    for (int f = 0; f < 14; f++) begin
      if (!writing && $urandom_range(3) == 0) begin
        int t;
        drive_beat({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, t);
      end
      rand_frame();
      send_frame(($urandom_range(5) == 0) ? int'($urandom_range(1, 3)) : 4,
                 int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 14)));
    end
    if (writing) begin
      rand_frame();
      send_frame(4, 0);
    end
    drain();

    // Reset in the middle of a readout.
    set_frame(34'h155);
    send_frame(4, 0);
    while (edge_n < last_s + 7) begin
      @(posedge clk);
      #1;
    end
    check_eq("pre_reset_valid", 64'(out_valid), 1);
    check_eq("pre_reset_data", 64'(data_out), 64'(34'h15C));
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 0);
    check_eq("async_rst_sof", 64'(out_sof), 0);
    check_eq("async_rst_data", 64'(data_out), 0);
    exp_q.delete();
    last_q.delete();
    writing = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    set_frame(34'h400);
    send_frame(4, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
